// File: rtl/reg_readback_pkg.sv
// reg_readback_pkg: shared definitions for the register readback transmitter.
// Holds the frame FSM state encoding, the default frame start byte, the
// frame-length helper and the index-width helper used by both the top and
// the shadow bank.
package reg_readback_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_ADDR,
        S_DATA_H,
        S_DATA_L,
        S_CSUM
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    function automatic int frame_len(input int num_regs, input bit csum_en);
        return 3 * num_regs + (csum_en ? 2 : 1);
    endfunction

    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction
endpackage

// File: rtl/register_shadow_bank.sv
// register_shadow_bank: snoops register bus writes and keeps a shadow copy of
// the window [BASE_ADDR, BASE_ADDR+NUM_REGS); writes outside it are ignored.
// Ports: clk, rst (sync, active-low), wr_addr_i/wr_data_i/wr_en_i (bus snoop),
//        rd_idx_i (slot index), rd_data_o (combinational slot read).
module register_shadow_bank
    import reg_readback_pkg::*;
#(
    parameter int                        REG_ADDR_WIDTH = 8,
    parameter int                        REG_DATA_WIDTH = 16,
    parameter logic [REG_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        NUM_REGS       = 12,
    localparam int                       IDX_W          = idx_width(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [REG_DATA_WIDTH-1:0] wr_data_i,
    input  logic                      wr_en_i,
    input  logic [IDX_W-1:0]          rd_idx_i,
    output logic [REG_DATA_WIDTH-1:0] rd_data_o
);
    logic [REG_DATA_WIDTH-1:0] shadow_q [NUM_REGS];
    logic [REG_ADDR_WIDTH-1:0] off;
    logic                      hit;

    // One extra bit on the compare so BASE_ADDR+NUM_REGS may pass the top of the address space.
    assign off = wr_addr_i - BASE_ADDR;
    assign hit = wr_en_i && (wr_addr_i >= BASE_ADDR) &&
                 ({1'b0, off} < (REG_ADDR_WIDTH+1)'(NUM_REGS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else if (hit) begin
            shadow_q[off[IDX_W-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = shadow_q[rd_idx_i];
endmodule

// File: rtl/register_readback_tx.sv
// register_readback_tx: on request, serialises a shadowed register window as
// HEADER, {ADDR, DATA_H, DATA_L} x NUM_REGS [, CSUM] onto a TX byte source.
// Ports: clk, rst (sync, active-low), register_addr/register_data/register_rdy
//        (bus snoop), rqst (readback request), tx_data/tx_rdy/tx_eof/tx_ack
//        (TX source), busy (frame in progress or pending).
// Option: define REG_READBACK_CHECKSUM_EN to append a modulo-256 checksum byte.
module register_readback_tx
    import reg_readback_pkg::*;
#(
    parameter int                        REG_ADDR_WIDTH = 8,
    parameter int                        REG_DATA_WIDTH = 16,
    parameter int                        TX_DATA_WIDTH  = 8,
    parameter logic [REG_ADDR_WIDTH-1:0] BASE_ADDR      = 8'h00,
    parameter int                        NUM_REGS       = 12,
    parameter logic [TX_DATA_WIDTH-1:0]  HEADER         = HEADER_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] register_addr,
    input  logic [REG_DATA_WIDTH-1:0] register_data,
    input  logic                      register_rdy,
    input  logic                      rqst,
    output logic [TX_DATA_WIDTH-1:0]  tx_data,
    output logic                      tx_rdy,
    output logic                      tx_eof,
    input  logic                      tx_ack,
    output logic                      busy
);
    localparam int               IDX_W = idx_width(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_REGS - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [REG_DATA_WIDTH-1:0] hold_q, hold_d, slot;
    logic                      pending_q, pending_d;
    logic [TX_DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                      tx_rdy_q, tx_rdy_d, tx_eof_q, tx_eof_d;
    logic                      adv;

    assign adv = tx_rdy_q && tx_ack;

    // Read port addressed by the next index so the hold register captures the
    // slot as it stands before any same-cycle bus write lands.
    register_shadow_bank #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .REG_DATA_WIDTH(REG_DATA_WIDTH),
        .BASE_ADDR     (BASE_ADDR),
        .NUM_REGS      (NUM_REGS)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_addr_i(register_addr),
        .wr_data_i(register_data),
        .wr_en_i  (register_rdy),
        .rd_idx_i (idx_d),
        .rd_data_o(slot)
    );

`ifdef REG_READBACK_CHECKSUM_EN
    logic [TX_DATA_WIDTH-1:0] csum_q, csum_d;
    assign csum_d = (state_q == S_IDLE) ? '0 : adv ? csum_q + tx_data_q : csum_q;
    always_ff @(posedge clk) csum_q <= !rst ? '0 : csum_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            tx_data_q <= '0;
            tx_rdy_q  <= 1'b0;
            tx_eof_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            tx_data_q <= tx_data_d;
            tx_rdy_q  <= tx_rdy_d;
            tx_eof_q  <= tx_eof_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: if (rqst || pending_q) begin
                state_d = S_HEADER;
                idx_d   = '0;
            end
            S_HEADER: if (adv) state_d = S_ADDR;
            S_ADDR:   if (adv) state_d = S_DATA_H;
            S_DATA_H: if (adv) state_d = S_DATA_L;
            S_DATA_L: if (adv) begin
                if (idx_q == LAST) begin
`ifdef REG_READBACK_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    state_d = S_ADDR;
                    idx_d   = idx_q + 1'b1;
                end
            end
`ifdef REG_READBACK_CHECKSUM_EN
            S_CSUM: if (adv) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // A request while a frame is running (including the eof-ack cycle) is
    // remembered once; the IDLE cycle that follows consumes it.
    assign pending_d = (state_q != S_IDLE) && (pending_q || rqst);
    assign hold_d    = (state_d == S_ADDR && state_q != S_ADDR) ? slot : hold_q;

    always_comb begin
        tx_rdy_d  = state_d != S_IDLE;
        tx_data_d = '0;
        unique case (state_d)
            S_HEADER: tx_data_d = HEADER;
            S_ADDR:   tx_data_d = TX_DATA_WIDTH'(BASE_ADDR + REG_ADDR_WIDTH'(idx_d));
            S_DATA_H: tx_data_d = TX_DATA_WIDTH'(hold_q[15:8]);
            S_DATA_L: tx_data_d = TX_DATA_WIDTH'(hold_q[7:0]);
`ifdef REG_READBACK_CHECKSUM_EN
            S_CSUM:   tx_data_d = csum_d;
`endif
            default:  tx_data_d = '0;
        endcase
`ifdef REG_READBACK_CHECKSUM_EN
        tx_eof_d = state_d == S_CSUM;
`else
        tx_eof_d = (state_d == S_DATA_L) && (idx_d == LAST);
`endif
    end

    assign tx_data = tx_data_q;
    assign tx_rdy  = tx_rdy_q;
    assign tx_eof  = tx_eof_q;
    assign busy    = (state_q != S_IDLE) || pending_q;
endmodule

// File: tb/tb_register_readback_tx.sv
// tb_register_readback_tx: scoreboard bench for register_readback_tx with a two-register window at 0x10.
module tb_register_readback_tx;
    import reg_readback_pkg::*;

`ifdef REG_READBACK_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  register_addr = '0;
    logic [15:0] register_data = '0;
    logic        register_rdy = 1'b0;
    logic        rqst = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_rdy, tx_eof;
    logic        tx_ack = 1'b1;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frames = 0;
    int eof_cyc = -100;
    int gap_from = 0;
    int nbytes = 0;
    int f0;
    bit mon_on = 1'b0;
    bit gap_chk = 1'b0;
    bit stall_prev = 1'b0;
    bit prev_rdy = 1'b0;
    logic [7:0] hold_data = '0;
    logic [8:0] exp_q [$];

    register_readback_tx #(
        .REG_ADDR_WIDTH(8),
        .REG_DATA_WIDTH(16),
        .TX_DATA_WIDTH (8),
        .BASE_ADDR     (8'h10),
        .NUM_REGS      (2),
        .HEADER        (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .register_addr(register_addr),
        .register_data(register_data),
        .register_rdy (register_rdy),
        .rqst         (rqst),
        .tx_data      (tx_data),
        .tx_rdy       (tx_rdy),
        .tx_eof       (tx_eof),
        .tx_ack       (tx_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        register_addr = a;
        register_data = d;
        register_rdy  = 1'b1;
        tick();
        register_rdy  = 1'b0;
    endtask

    task automatic req();
        rqst = 1'b1;
        tick();
        rqst = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] r0, input logic [15:0] r1);
        logic [7:0] b [7];
        logic [7:0] sum;
        b = '{8'hA5, 8'h10, r0[15:8], r0[7:0], 8'h11, r1[15:8], r1[7:0]};
        sum = '0;
        for (int i = 0; i < 7; i++) begin
            sum = sum + b[i];
            exp_q.push_back({(!CS && i == 6), b[i]});
        end
        if (CS) exp_q.push_back({1'b1, sum});
    endtask

    task automatic wait_done(input bit rnd);
        bit done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            if (rnd) tx_ack = 1'($urandom_range(0, 1));
            tick();
            done = (exp_q.size() == 0) && !busy;
        end
        tx_ack = 1'b1;
        if (!done) check("timeout", 32'd1, 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (stall_prev) begin
                check("stall_data", tx_data, hold_data);
                check("stall_rdy", tx_rdy, 1);
            end
            if (tx_rdy && !prev_rdy) begin
                nbytes = 0;
                if (gap_chk && eof_cyc >= gap_from) check("gap", cyc - eof_cyc, 2);
            end
            if (tx_rdy && tx_ack) begin
                nbytes++;
                if (exp_q.size() == 0) begin
                    check("sb_empty", {24'd0, tx_data}, 32'hFFFF);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("data", tx_data, e[7:0]);
                    check("eof", tx_eof, e[8]);
                end
                if (tx_eof) begin
                    frames++;
                    eof_cyc = cyc;
                    check("len", nbytes, frame_len(2, CS));
                end
            end
        end
        stall_prev = tx_rdy && !tx_ack;
        hold_data  = tx_data;
        prev_rdy   = tx_rdy;
    end

    initial begin
        repeat (3) tick();
        check("rst_rdy", tx_rdy, 0);
        check("rst_eof", tx_eof, 0);
        check("rst_data", tx_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        tick();
        mon_on = 1'b1;

        // 1: defaults and request latency
        push_frame(16'h0000, 16'h0000);
        rqst = 1'b1;
        tick();
        rqst = 1'b0;
        check("lat_rdy", tx_rdy, 1);
        check("lat_hdr", tx_data, 8'hA5);
        check("lat_busy", busy, 1);
        wait_done(1'b0);

        // 2: written values
        wr(8'h10, 16'h1234);
        wr(8'h11, 16'h0000);
        push_frame(16'h1234, 16'h0000);
        req();
        wait_done(1'b0);

        // 3: random backpressure
        push_frame(16'h1234, 16'h0000);
        req();
        wait_done(1'b1);
        push_frame(16'h1234, 16'h0000);
        req();
        wait_done(1'b1);

        // 4: requests during a frame, write during HEADER
        gap_from = cyc;
        gap_chk = 1'b1;
        f0 = frames;
        rqst = 1'b1;
        tick();
        rqst = 1'b0;
        push_frame(16'h1234, 16'hBEEF);
        push_frame(16'h1234, 16'hBEEF);
        wr(8'h11, 16'hBEEF);
        tick();
        req();
        tick();
        req();
        wait_done(1'b0);
        check("frames", frames - f0, 2);
        gap_chk = 1'b0;

        // 5: ignored writes and idle acks
        wr(8'h12, 16'hDEAD);
        wr(8'h0F, 16'hCAFE);
        for (int i = 0; i < 6; i++) begin
            tx_ack = 1'(i[0]);
            tick();
            check("idle_rdy", tx_rdy, 0);
            check("idle_busy", busy, 0);
        end
        tx_ack = 1'b1;
        push_frame(16'h1234, 16'hBEEF);
        req();
        wait_done(1'b0);

        // 6: reset during DATA_H
        mon_on = 1'b0;
        req();
        tick();
        tick();
        check("pre_rst_dh", tx_data, 8'h12);
        rst = 1'b0;
        tick();
        check("mid_rst_rdy", tx_rdy, 0);
        check("mid_rst_eof", tx_eof, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b1;
        tick();
        mon_on = 1'b1;
        push_frame(16'h0000, 16'h0000);
        req();
        wait_done(1'b0);
        check("sb_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/register_readback_tx.md
# register_readback_tx

Transmit side of the host register protocol: snoops the shared register bus, keeps a shadow copy of a contiguous window of configuration registers, and on a host request serialises that window into a byte frame. The frame is presented on a simple-interface TX source toward the TX protocol mux. It is the reader/transmitter counterpart of the RX block, which decodes host bytes into register writes.

## Interface
- `REG_ADDR_WIDTH`, 8: register bus address width.
- `REG_DATA_WIDTH`, 16: register bus data width; fixed at 16 (two payload bytes).
- `TX_DATA_WIDTH`, 8: TX byte width.
- `BASE_ADDR`, 8'h00: first shadowed register address.
- `NUM_REGS`, 12: number of shadowed registers, range 1..64.
- `HEADER`, 8'hA5: frame start byte.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `register_addr` in REG_ADDR_WIDTH: register bus address.
- `register_data` in REG_DATA_WIDTH: register bus data.
- `register_rdy` in 1: one-cycle write strobe.
- `rqst` in 1: one-cycle readback request from the RX block.
- `tx_data` out TX_DATA_WIDTH: frame byte.
- `tx_rdy` out 1: byte valid.
- `tx_eof` out 1: current byte is last of frame.
- `tx_ack` in 1: byte consumed.
- `busy` out 1: high while a frame is in progress or pending.

## Operation
- Shadow: on `register_rdy`, if BASE_ADDR ≤ `register_addr` < BASE_ADDR+NUM_REGS, store `register_data` to slot (addr−BASE_ADDR). Out-of-window writes are ignored. Shadows reset to 0.
- Frame: HEADER, then for i=0..NUM_REGS−1 three bytes: ADDR (BASE_ADDR+i, low 8 bits), DATA_H [15:8], DATA_L [7:0].
- FSM states: IDLE → HEADER → ADDR → DATA_H → DATA_L → (ADDR if i<NUM_REGS−1, else IDLE).
- Every state advances only on `tx_rdy && tx_ack`.
- On entering ADDR, slot i is latched into a 16-bit hold register. DATA_H/DATA_L come from the hold register, so each register's two bytes are coherent.
- Same-cycle write to slot i while entering ADDR i: the hold captures the old value; the shadow takes the new value.
- `rqst` in IDLE starts a frame. `rqst` while busy sets a single pending flag; further requests are merged into it.
- After the eof byte is acked, the FSM returns to IDLE. If pending is set, it clears pending and starts a new frame.
- `rqst` in the same cycle as the eof ack sets pending.
- `busy` = (state≠IDLE) | pending.

## Timing
- Reset values: `tx_rdy`=0, `tx_eof`=0, `tx_data`=0, `busy`=0, state IDLE, pending 0, index 0.
- `rqst` at cycle n → `tx_rdy`=1 with HEADER at n+1.
- Throughput: with `tx_ack` held high, one byte per cycle. `tx_rdy` stays high with no bubble between bytes of a frame.
- `tx_data`, `tx_eof` and `tx_rdy` are registered. They are held stable while `tx_rdy && !tx_ack`.
- `tx_ack` without `tx_rdy` is ignored.
- A pending frame's HEADER appears one cycle after the IDLE cycle that follows the eof ack (one-cycle gap).
- Reset mid-frame drops the frame. Outputs return to reset values on the next edge; no eof is emitted.

## Configuration
- `REG_READBACK_CHECKSUM_EN` defined: a CSUM state is appended after the final DATA_L.
  - The trailing byte is the 8-bit modulo-256 sum of all preceding frame bytes, HEADER included.
  - `tx_eof` is asserted on the CSUM byte.
  - Frame length is 3·NUM_REGS+2.
- Undefined: no CSUM state, `tx_eof` is asserted on the final DATA_L, and frame length is 3·NUM_REGS+1.

## Structure
- Shared package `reg_readback_pkg` holds:
  - the state encoding;
  - the HEADER default;
  - a frame-length function of NUM_REGS and the checksum flag.
- Sub-module `register_shadow_bank` holds the bus snoop, window decode, shadow array and read port by index. Its parameters are BASE_ADDR, NUM_REGS and the widths.
- The top holds the FSM, index counter, hold register, pending flag and checksum accumulator.

## Test plan
Unless noted, tests use NUM_REGS=2, BASE_ADDR=8'h10, and `tx_ack` held 1.

1. Defaults: reset, then `rqst` → bytes A5 10 00 00 11 00 00. `tx_eof` is on the 7th byte only.
2. Writes: write 0x10←16'h1234 and 0x11←16'h0000, then `rqst` → A5 10 12 34 11 00 00.
   - With `REG_READBACK_CHECKSUM_EN`, an 8th byte 0C carries `tx_eof`.
3. Backpressure: toggle `tx_ack` randomly → byte sequence identical to test 2. `tx_data` is held stable while un-acked.
4. Requests during a frame: two `rqst` pulses mid-frame → exactly one extra frame, with one idle cycle between frames. A write to 0x11←16'hBEEF during the first frame's HEADER makes the first frame already show BE EF.
5. Ignored inputs: write to 0x12 or 0x0F → no effect on the frame. `tx_ack` pulses while idle → no output.
6. Reset mid-frame: assert `rst` low during DATA_H → `tx_rdy`=0 next cycle and shadows read back 0. A subsequent `rqst` → A5 10 00 00 11 00 00.
